sequential_param: RTL and testbench
===================================

// Module: sequential_param
//
// PURPOSE
// Parametrised WIDTH-bit counter / shift register, next generation of the 16-bit sequential counter.
// Adds modulo limit, wrap/saturate mode, programmable step, rotate, serial outputs and status flags.
// Sits in datapath/control as a general event counter, timer prescaler or serial (de)serialiser.
// All state is registered. Commands are level inputs sampled on posedge Clock.
//
// PARAMETERS
// WIDTH      16            counter/shift register width, >= 2
// STEP_W     4             width of CounterStep, STEP_W <= WIDTH
// MAX_VALUE  2**WIDTH-1    modulo upper limit for count ops, 1 <= MAX_VALUE <= 2**WIDTH-1
// SATURATE   0             0: count ops wrap modulo MAX_VALUE+1; 1: clamp at 0 / MAX_VALUE
//
// PORTS
// Clock          in   1        rising-edge clock
// nReset         in   1        asynchronous, active-low reset
// CounterOut     out  WIDTH    current value
// CounterInData  in   WIDTH    parallel load data
// CounterInMSB   in   1        serial input bit for ShiftL2R (enters bit WIDTH-1)
// CounterInLSB   in   1        serial input bit for ShiftR2L (enters bit 0)
// CounterStep    in   STEP_W   increment/decrement amount; 0 = hold (no flags)
// DoClear        in   1        synchronous clear
// DoLoad         in   1        parallel load
// DoIncrement    in   1        value += CounterStep
// DoDecrement    in   1        value -= CounterStep
// DoShiftL2R     in   1        shift towards LSB
// DoShiftR2L     in   1        shift towards MSB
// DoRotate       in   1        1: shifts rotate (serial inputs ignored)
// SerialOutLSB   out  1        bit shifted out by last ShiftL2R (old bit 0)
// SerialOutMSB   out  1        bit shifted out by last ShiftR2L (old bit WIDTH-1)
// TerminalCount  out  1        1-cycle pulse: last count op wrapped or saturated
// Overflow       out  1        sticky: any wrap/saturate/clamped load since last Clear/Load
//
// BEHAVIOUR
// - nReset=0 (async): CounterOut=0, SerialOutLSB=0, SerialOutMSB=0, TerminalCount=0, Overflow=0.
// - Fixed priority per cycle: DoClear > DoLoad > DoIncrement > DoDecrement > DoShiftL2R > DoShiftR2L > hold.
//   Exactly one op executes; lower-priority commands that cycle are ignored.
// - Latency: result visible on CounterOut and flags one cycle after the command edge.
// - Clear: value=0, Overflow=0, TerminalCount=0; serial outputs unchanged.
// - Load: value=min(CounterInData, MAX_VALUE); Overflow=1 iff clamped, else 0; TerminalCount=0.
// - Count ops: let v=min(value,MAX_VALUE), s=CounterStep zero-extended; arithmetic in WIDTH+1 bits.
//   Inc: v+s<=MAX_VALUE -> v+s; else wrap: v+s-(MAX_VALUE+1) (mod MAX_VALUE+1), sat: MAX_VALUE.
//   Dec: s<=v -> v-s; else wrap: v+(MAX_VALUE+1)-s (mod MAX_VALUE+1), sat: 0.
//   On wrap/sat: TerminalCount=1 that cycle, Overflow set. s=0: value held, no flags.
//   Saturate at limit with further count -> value holds, TerminalCount pulses each cycle.
// - ShiftL2R: value={in,value[WIDTH-1:1]}, in=DoRotate?value[0]:CounterInMSB; SerialOutLSB=value[0].
// - ShiftR2L: value={value[WIDTH-2:0],in}, in=DoRotate?value[WIDTH-1]:CounterInLSB; SerialOutMSB=value[WIDTH-1].
// - Shifts ignore MAX_VALUE (may leave value > MAX_VALUE); following count op uses v=MAX_VALUE.
// - TerminalCount is 0 in every cycle without a wrapping/saturating count op.
// - Overflow only cleared by DoClear, non-clamped DoLoad or nReset.
// - nReset asserted mid-operation overrides all commands immediately.
//
// TESTING (WIDTH=16, STEP_W=4 unless noted)
// 1 Reset: nReset low mid-increment -> all outputs 0 asynchronously; release, no command -> value holds 0.
// 2 Wrap, MAX_VALUE=9, SATURATE=0: Load 8, Step=3, Inc -> 1, TerminalCount pulse 1 cycle, Overflow=1;
//   Dec Step=2 -> 9 with pulse; Clear -> 0, Overflow=0.
// 3 Saturate, MAX_VALUE=9, SATURATE=1: Load 7, Step=2, Inc x3 -> 9,9,9, TerminalCount 0,1,1;
//   Load 20 -> 9, Overflow=1.
// 4 Priority: Clear+Load+Inc same cycle -> 0; Inc+Dec+ShiftL2R with value 5, Step=1 -> 6.
// 5 Shift: Load 16'h8001, ShiftL2R CounterInMSB=0 -> 16'h4000, SerialOutLSB=1; DoRotate=1 ShiftR2L x2
//   from 16'h8001 -> 16'h0003 then 16'h0006, SerialOutMSB=1 then 0.
// 6 Step=0 Inc at MAX_VALUE -> value held, TerminalCount=0, Overflow unchanged.

Source files
------------

// File: rtl/sequential_param.sv
`default_nettype none
// ============================================================================
// Module   : sequential_param
// Brief    : Parametrised WIDTH-bit counter / shift register with modulo
//            limit, wrap or saturate mode, programmable step, rotate,
//            serial outputs and terminal-count / sticky overflow flags.
// Revision : 1.0  initial release
// ============================================================================
module sequential_param #(
  parameter int                 WIDTH     = 16,
  parameter int                 STEP_W    = 4,
  parameter logic [WIDTH-1:0]   MAX_VALUE = {WIDTH{1'b1}},
  parameter int                 SATURATE  = 0
) (
  input  logic              Clock,
  input  logic              nReset,
  output logic [WIDTH-1:0]  CounterOut,
  input  logic [WIDTH-1:0]  CounterInData,
  input  logic              CounterInMSB,
  input  logic              CounterInLSB,
  input  logic [STEP_W-1:0] CounterStep,
  input  logic              DoClear,
  input  logic              DoLoad,
  input  logic              DoIncrement,
  input  logic              DoDecrement,
  input  logic              DoShiftL2R,
  input  logic              DoShiftR2L,
  input  logic              DoRotate,
  output logic              SerialOutLSB,
  output logic              SerialOutMSB,
  output logic              TerminalCount,
  output logic              Overflow
);

  // Count arithmetic runs one bit wider so MAX_VALUE+1 is representable.
  localparam logic [WIDTH:0] C_MAX_EXT = {1'b0, MAX_VALUE};
  localparam logic [WIDTH:0] C_MOD     = C_MAX_EXT + 1'b1;

  logic [WIDTH-1:0] value_q, value_d;
  logic             ser_lsb_q, ser_lsb_d;
  logic             ser_msb_q, ser_msb_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;

  // Operands: a value above the limit (left there by a shift) counts as MAX_VALUE.
  // The step is reduced modulo MAX_VALUE+1 so a step larger than the range
  // still wraps to the correct residue.
  logic [WIDTH:0]   v_ext;
  logic [WIDTH:0]   s_ext;
  logic [WIDTH:0]   s_mod;
  logic [WIDTH:0]   sum_raw;
  logic [WIDTH:0]   sum_mod;
  logic [WIDTH-1:0] inc_wrap;
  logic [WIDTH-1:0] dec_wrap;
  logic [WIDTH-1:0] shr_val;
  logic [WIDTH-1:0] shl_val;

  assign v_ext    = (value_q > MAX_VALUE) ? C_MAX_EXT : {1'b0, value_q};
  assign s_ext    = {{(WIDTH+1-STEP_W){1'b0}}, CounterStep};
  assign s_mod    = s_ext % C_MOD;
  assign sum_raw  = v_ext + s_ext;
  assign sum_mod  = v_ext + s_mod;
  assign inc_wrap = WIDTH'((sum_mod > C_MAX_EXT) ? (sum_mod - C_MOD) : sum_mod);
  assign dec_wrap = WIDTH'((s_mod <= v_ext) ? (v_ext - s_mod) : (v_ext + C_MOD - s_mod));
  assign shr_val  = {(DoRotate ? value_q[0] : CounterInMSB), value_q[WIDTH-1:1]};
  assign shl_val  = {value_q[WIDTH-2:0], (DoRotate ? value_q[WIDTH-1] : CounterInLSB)};

  // Next-state selection with fixed command priority; exactly one op per cycle.
  always_comb begin
    value_d   = value_q;
    ser_lsb_d = ser_lsb_q;
    ser_msb_d = ser_msb_q;
    tc_d      = 1'b0;
    ovf_d     = ovf_q;
    if (DoClear) begin
      value_d = '0;
      ovf_d   = 1'b0;
    end else if (DoLoad) begin
      if (CounterInData > MAX_VALUE) begin
        value_d = MAX_VALUE;
        ovf_d   = 1'b1;
      end else begin
        value_d = CounterInData;
        ovf_d   = 1'b0;
      end
    end else if (DoIncrement) begin
      if (s_ext != '0) begin
        if (sum_raw > C_MAX_EXT) begin
          tc_d    = 1'b1;
          ovf_d   = 1'b1;
          value_d = (SATURATE != 0) ? MAX_VALUE : inc_wrap;
        end else begin
          value_d = WIDTH'(sum_raw);
        end
      end
    end else if (DoDecrement) begin
      if (s_ext != '0) begin
        if (s_ext > v_ext) begin
          tc_d    = 1'b1;
          ovf_d   = 1'b1;
          value_d = (SATURATE != 0) ? '0 : dec_wrap;
        end else begin
          value_d = WIDTH'(v_ext - s_ext);
        end
      end
    end else if (DoShiftL2R) begin
      value_d   = shr_val;
      ser_lsb_d = value_q[0];
    end else if (DoShiftR2L) begin
      value_d   = shl_val;
      ser_msb_d = value_q[WIDTH-1];
    end
  end

  // State and flag registers, cleared asynchronously.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      value_q   <= '0;
      ser_lsb_q <= 1'b0;
      ser_msb_q <= 1'b0;
      tc_q      <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      value_q   <= value_d;
      ser_lsb_q <= ser_lsb_d;
      ser_msb_q <= ser_msb_d;
      tc_q      <= tc_d;
      ovf_q     <= ovf_d;
    end
  end

  assign CounterOut    = value_q;
  assign SerialOutLSB  = ser_lsb_q;
  assign SerialOutMSB  = ser_msb_q;
  assign TerminalCount = tc_q;
  assign Overflow      = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_sequential_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_sequential_param
// Brief    : Directed self-checking bench for sequential_param. Three
//            instances share the inputs: full-range default, modulo-10 wrap
//            and modulo-10 saturate.
// Revision : 1.0  initial release
// ============================================================================
module tb_sequential_param;

  logic        Clock = 1'b0;
  logic        nReset;
  logic [15:0] CounterInData;
  logic        CounterInMSB, CounterInLSB;
  logic [3:0]  CounterStep;
  logic        DoClear, DoLoad, DoIncrement, DoDecrement;
  logic        DoShiftL2R, DoShiftR2L, DoRotate;

  logic [15:0] d_out, w_out, s_out;
  logic        d_slsb, d_smsb, d_tc, d_ovf;
  logic        w_slsb, w_smsb, w_tc, w_ovf;
  logic        s_slsb, s_smsb, s_tc, s_ovf;

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  sequential_param u_def (
    .Clock(Clock), .nReset(nReset), .CounterOut(d_out), .CounterInData(CounterInData),
    .CounterInMSB(CounterInMSB), .CounterInLSB(CounterInLSB), .CounterStep(CounterStep),
    .DoClear(DoClear), .DoLoad(DoLoad), .DoIncrement(DoIncrement), .DoDecrement(DoDecrement),
    .DoShiftL2R(DoShiftL2R), .DoShiftR2L(DoShiftR2L), .DoRotate(DoRotate),
    .SerialOutLSB(d_slsb), .SerialOutMSB(d_smsb), .TerminalCount(d_tc), .Overflow(d_ovf));

  sequential_param #(.MAX_VALUE(16'd9), .SATURATE(0)) u_wrap (
    .Clock(Clock), .nReset(nReset), .CounterOut(w_out), .CounterInData(CounterInData),
    .CounterInMSB(CounterInMSB), .CounterInLSB(CounterInLSB), .CounterStep(CounterStep),
    .DoClear(DoClear), .DoLoad(DoLoad), .DoIncrement(DoIncrement), .DoDecrement(DoDecrement),
    .DoShiftL2R(DoShiftL2R), .DoShiftR2L(DoShiftR2L), .DoRotate(DoRotate),
    .SerialOutLSB(w_slsb), .SerialOutMSB(w_smsb), .TerminalCount(w_tc), .Overflow(w_ovf));

  sequential_param #(.MAX_VALUE(16'd9), .SATURATE(1)) u_sat (
    .Clock(Clock), .nReset(nReset), .CounterOut(s_out), .CounterInData(CounterInData),
    .CounterInMSB(CounterInMSB), .CounterInLSB(CounterInLSB), .CounterStep(CounterStep),
    .DoClear(DoClear), .DoLoad(DoLoad), .DoIncrement(DoIncrement), .DoDecrement(DoDecrement),
    .DoShiftL2R(DoShiftL2R), .DoShiftR2L(DoShiftR2L), .DoRotate(DoRotate),
    .SerialOutLSB(s_slsb), .SerialOutMSB(s_smsb), .TerminalCount(s_tc), .Overflow(s_ovf));

  // Drop all commands.
  task automatic idle();
    DoClear = 0; DoLoad = 0; DoIncrement = 0; DoDecrement = 0;
    DoShiftL2R = 0; DoShiftR2L = 0; DoRotate = 0;
    CounterInMSB = 0; CounterInLSB = 0;
  endtask

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic load(input logic [15:0] d);
    idle(); DoLoad = 1; CounterInData = d; tick(); idle();
  endtask

  task automatic test_reset();
    idle(); CounterStep = 4'd1; DoIncrement = 1;
    tick(); tick();
    #2 nReset = 1'b0;
    #1;
    checks++; if (d_out !== 16'h0) begin errors++; $display("FAIL reset_value: got %h want 0000", d_out); end
    checks++; if ({d_slsb, d_smsb, d_tc, d_ovf} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b want 0000", {d_slsb, d_smsb, d_tc, d_ovf}); end
    checks++; if (w_out !== 16'h0) begin errors++; $display("FAIL reset_wrap_value: got %h want 0000", w_out); end
    idle();
    @(negedge Clock);
    nReset = 1'b1;
    tick();
    checks++; if (d_out !== 16'h0) begin errors++; $display("FAIL reset_hold: got %h want 0000", d_out); end
  endtask

  task automatic test_wrap();
    load(16'd8);
    checks++; if (w_out !== 16'd8) begin errors++; $display("FAIL wrap_load: got %0d want 8", w_out); end
    CounterStep = 4'd3; DoIncrement = 1; tick(); idle();
    checks++; if (w_out !== 16'd1) begin errors++; $display("FAIL wrap_inc: got %0d want 1", w_out); end
    checks++; if ({w_tc, w_ovf} !== 2'b11) begin errors++; $display("FAIL wrap_inc_flags: got %b want 11", {w_tc, w_ovf}); end
    tick();
    checks++; if ({w_tc, w_ovf} !== 2'b01) begin errors++; $display("FAIL wrap_tc_pulse: got %b want 01", {w_tc, w_ovf}); end
    CounterStep = 4'd2; DoDecrement = 1; tick(); idle();
    checks++; if (w_out !== 16'd9 || w_tc !== 1'b1) begin errors++; $display("FAIL wrap_dec: got %0d tc %b want 9 tc 1", w_out, w_tc); end
    DoClear = 1; tick(); idle();
    checks++; if (w_out !== 16'd0 || w_ovf !== 1'b0) begin errors++; $display("FAIL wrap_clear: got %0d ovf %b want 0 ovf 0", w_out, w_ovf); end
    // Step larger than the modulus: (5 - 12) mod 10 = 3.
    load(16'd5);
    CounterStep = 4'd12; DoDecrement = 1; tick(); idle();
    checks++; if (w_out !== 16'd3 || w_tc !== 1'b1) begin errors++; $display("FAIL wrap_big_step: got %0d tc %b want 3 tc 1", w_out, w_tc); end
    // Shift past the limit, then a count treats the value as MAX_VALUE.
    load(16'd9);
    DoShiftR2L = 1; CounterInLSB = 1; tick(); idle();
    checks++; if (w_out !== 16'd19) begin errors++; $display("FAIL shift_above_max: got %0d want 19", w_out); end
    CounterStep = 4'd1; DoIncrement = 1; tick(); idle();
    checks++; if (w_out !== 16'd0 || w_tc !== 1'b1) begin errors++; $display("FAIL inc_above_max: got %0d tc %b want 0 tc 1", w_out, w_tc); end
  endtask

  task automatic test_saturate();
    logic [15:0] exp_v [3] = '{16'd9, 16'd9, 16'd9};
    logic        exp_t [3] = '{1'b0, 1'b1, 1'b1};
    load(16'd7);
    CounterStep = 4'd2; DoIncrement = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (s_out !== exp_v[i] || s_tc !== exp_t[i]) begin errors++; $display("FAIL sat_inc%0d: got %0d tc %b want %0d tc %b", i, s_out, s_tc, exp_v[i], exp_t[i]); end
    end
    idle();
    checks++; if (s_ovf !== 1'b1) begin errors++; $display("FAIL sat_ovf: got %b want 1", s_ovf); end
    load(16'd0);
    CounterStep = 4'd3; DoDecrement = 1; tick(); idle();
    checks++; if (s_out !== 16'd0 || s_tc !== 1'b1) begin errors++; $display("FAIL sat_dec: got %0d tc %b want 0 tc 1", s_out, s_tc); end
    load(16'd20);
    checks++; if (s_out !== 16'd9 || s_ovf !== 1'b1 || s_tc !== 1'b0) begin errors++; $display("FAIL sat_clamp_load: got %0d ovf %b tc %b want 9 ovf 1 tc 0", s_out, s_ovf, s_tc); end
  endtask

  task automatic test_priority();
    load(16'd5);
    DoClear = 1; DoLoad = 1; DoIncrement = 1; CounterInData = 16'd7; CounterStep = 4'd1;
    tick(); idle();
    checks++; if (d_out !== 16'd0) begin errors++; $display("FAIL prio_clear: got %0d want 0", d_out); end
    load(16'd5);
    DoIncrement = 1; DoDecrement = 1; DoShiftL2R = 1; CounterStep = 4'd1;
    tick(); idle();
    checks++; if (d_out !== 16'd6) begin errors++; $display("FAIL prio_inc: got %0d want 6", d_out); end
  endtask

  task automatic test_shift();
    load(16'h8001);
    DoShiftL2R = 1; CounterInMSB = 0; tick(); idle();
    checks++; if (d_out !== 16'h4000 || d_slsb !== 1'b1) begin errors++; $display("FAIL shift_l2r: got %h slsb %b want 4000 slsb 1", d_out, d_slsb); end
    load(16'h8001);
    DoRotate = 1; DoShiftR2L = 1; tick();
    checks++; if (d_out !== 16'h0003 || d_smsb !== 1'b1) begin errors++; $display("FAIL rot_r2l_1: got %h smsb %b want 0003 smsb 1", d_out, d_smsb); end
    tick(); idle();
    checks++; if (d_out !== 16'h0006 || d_smsb !== 1'b0) begin errors++; $display("FAIL rot_r2l_2: got %h smsb %b want 0006 smsb 0", d_out, d_smsb); end
    checks++; if (d_slsb !== 1'b1) begin errors++; $display("FAIL slsb_kept: got %b want 1", d_slsb); end
  endtask

  task automatic test_step_zero();
    load(16'd20);
    CounterStep = 4'd0; DoIncrement = 1; tick(); idle();
    checks++; if (s_out !== 16'd9 || s_tc !== 1'b0 || s_ovf !== 1'b1) begin errors++; $display("FAIL step_zero: got %0d tc %b ovf %b want 9 tc 0 ovf 1", s_out, s_tc, s_ovf); end
  endtask

  initial begin
    nReset = 1'b0; CounterInData = '0; CounterStep = '0;
    idle();
    #12 nReset = 1'b1;
    test_reset();
    test_wrap();
    test_saturate();
    test_priority();
    test_shift();
    test_step_zero();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
